// File: rtl/mire_writer.sv
// rtl/mire_writer.sv - grid test-pattern frame writer, Wishbone classic-cycle master
//
// Writes one frame of a grid pattern into a row-major, one-word-per-pixel
// frame buffer at base address 0. A pixel is white (24'hFFFFFF) when
// x[3:0]==0 or y[3:0]==0 and black otherwise; the top byte is always 0.
// The bus request is dropped for one cycle after every BURST accepted
// writes so that the arbiter can serve the display reader.
//
// Optional feature macro: MIRE_CONTINUOUS_EN
//   defined   : the frame is rewritten indefinitely, done stays 0
//   undefined : one frame is written, then done=1 until reset
//
// Parameters:
//   HDISP        visible pixels per line
//   VDISP        visible lines per frame
//   BURST        writes accepted per bus tenure before a forced release (>=1)
//
// Ports:
//   wshb_clk     in   1   clock
//   wshb_rst     in   1   synchronous active-high reset
//   wshb_cyc     out  1   bus cycle request
//   wshb_stb     out  1   strobe
//   wshb_we      out  1   write enable (follows stb)
//   wshb_adr     out  32  byte address
//   wshb_dat_ms  out  32  write data
//   wshb_sel     out  4   byte select, all lanes
//   wshb_cti     out  3   classic cycle
//   wshb_bte     out  2   linear burst type (unused)
//   wshb_ack     in   1   slave acknowledge
//   done         out  1   frame complete (single-shot build)
//   frame_count  out  8   completed frames, wraps 255->0

module mire_writer #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int BURST = 64
) (
    input  logic        wshb_clk,
    input  logic        wshb_rst,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    input  logic        wshb_ack,
    output logic        done,
    output logic [7:0]  frame_count
);

    // Counters are at least 4 bits wide so the grid test on [3:0] is
    // always legal, even for tiny test geometries.
    localparam int XW = ($clog2(HDISP) < 4) ? 4 : $clog2(HDISP);
    localparam int YW = ($clog2(VDISP) < 4) ? 4 : $clog2(VDISP);
    localparam int BW = ($clog2(BURST + 1) < 1) ? 1 : $clog2(BURST + 1);

    typedef enum logic [1:0] {
        RESET_WAIT = 2'd0,
        WRITE      = 2'd1,
        PAUSE      = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [BW-1:0]   burst_cnt;
    logic            cyc_q;
    logic            stb_q;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;

    logic            last_x;
    logic            last_y;
    logic            last_pixel;
    logic            burst_end;
    logic [XW-1:0]   next_x;
    logic [YW-1:0]   next_y;

    function automatic logic [31:0] pixel(input logic [XW-1:0] px,
                                          input logic [YW-1:0] py);
        logic grid;
        grid = (px[3:0] == 4'd0) || (py[3:0] == 4'd0);
        return {8'h00, grid ? 24'hFFFFFF : 24'h000000};
    endfunction

    // Position of the word that follows the one currently on the bus.
    always_comb begin
        last_x     = (x == XW'(HDISP - 1));
        last_y     = (y == YW'(VDISP - 1));
        last_pixel = last_x && last_y;
        burst_end  = (burst_cnt == BW'(BURST - 1));
        next_x     = last_x ? '0 : x + 1'b1;
        next_y     = y;
        if (last_x) begin
            next_y = last_y ? '0 : y + 1'b1;
        end
    end

    always_ff @(posedge wshb_clk) begin
        if (wshb_rst) begin
            state       <= RESET_WAIT;
            x           <= '0;
            y           <= '0;
            burst_cnt   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= 32'd0;
            dat_q       <= pixel('0, '0);
            done        <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            case (state)
                RESET_WAIT: begin
                    state <= WRITE;
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                end

                WRITE: begin
                    // Without ack everything holds, keeping adr/dat/we stable.
                    if (wshb_ack) begin
                        x     <= next_x;
                        y     <= next_y;
                        dat_q <= pixel(next_x, next_y);
                        if (last_pixel) begin
                            // Frame end always releases the bus once; a
                            // coinciding burst boundary does not add a second
                            // pause, it only clears the burst counter.
                            adr_q       <= 32'd0;
                            burst_cnt   <= '0;
                            frame_count <= frame_count + 8'd1;
                            cyc_q       <= 1'b0;
                            stb_q       <= 1'b0;
`ifdef MIRE_CONTINUOUS_EN
                            state       <= PAUSE;
`else
                            state       <= DONE;
                            done        <= 1'b1;
`endif
                        end else if (burst_end) begin
                            adr_q     <= adr_q + 32'd4;
                            burst_cnt <= '0;
                            cyc_q     <= 1'b0;
                            stb_q     <= 1'b0;
                            state     <= PAUSE;
                        end else begin
                            adr_q     <= adr_q + 32'd4;
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end

                PAUSE: begin
                    state <= WRITE;
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                end

                DONE: begin
                    cyc_q <= 1'b0;
                    stb_q <= 1'b0;
                end

                default: begin
                    state <= RESET_WAIT;
                    cyc_q <= 1'b0;
                    stb_q <= 1'b0;
                end
            endcase
        end
    end

    assign wshb_cyc    = cyc_q;
    assign wshb_stb    = stb_q;
    assign wshb_we     = stb_q;
    assign wshb_adr    = adr_q;
    assign wshb_dat_ms = dat_q;
    assign wshb_sel    = 4'b1111;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;

endmodule

// File: tb/tb_mire_writer.sv
// tb/tb_mire_writer.sv - directed self-checking bench for mire_writer
module tb_mire_writer;

    localparam int H    = 32;
    localparam int V    = 4;
    localparam int B    = 8;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ack = 1'b0;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        done;
    logic [7:0]  frame_count;

    mire_writer #(.HDISP(H), .VDISP(V), .BURST(B)) dut (
        .wshb_clk    (clk),
        .wshb_rst    (rst),
        .wshb_cyc    (cyc),
        .wshb_stb    (stb),
        .wshb_we     (we),
        .wshb_adr    (adr),
        .wshb_dat_ms (dat),
        .wshb_sel    (sel),
        .wshb_cti    (cti),
        .wshb_bte    (bte),
        .wshb_ack    (ack),
        .done        (done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem [NPIX];
    int          n_wr;
    int          n_falls;
    int          acks_since_fall;
    int          low_cnt;
    bit          in_pause;
    bit          rand_ack;
    bit          wrap_seen;
    int          stall;
    logic [31:0] exp_adr;
    logic [31:0] pause_adr;
    logic [31:0] last_acc_adr;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] grid_px(input int i);
        int px;
        int py;
        px = i % H;
        py = i / H;
        return ((px % 16 == 0) || (py % 16 == 0)) ? 32'h00FFFFFF : 32'h0;
    endfunction

    task automatic clear_book();
        for (int i = 0; i < NPIX; i++) mem[i] = 32'hDEADBEEF;
        n_wr            = 0;
        n_falls         = 0;
        acks_since_fall = 0;
        low_cnt         = 0;
        in_pause        = 1'b0;
        exp_adr         = 32'd0;
        wrap_seen       = 1'b0;
        last_acc_adr    = 32'd0;
    endtask

    // One clock: choose ack, log an accepted write, step past the edge,
    // then check stall stability and pause behaviour.
    task automatic tick();
        logic        accept;
        logic        hold;
        logic        prev_stb;
        logic [64:0] held;
        if (rand_ack) begin
            if (!stb) begin
                ack = 1'($urandom_range(0, 1));
            end else if (stall > 0) begin
                ack = 1'b0;
                stall--;
            end else begin
                ack = 1'b1;
                stall = $urandom_range(0, 5);
            end
        end
        accept = stb && ack && !rst;
        hold   = stb && !ack && !rst;
        held   = {we, adr, dat};
        prev_stb = stb;
        if (accept) begin
            check("adr_seq", adr, exp_adr);
            if (adr == 32'd0 && last_acc_adr == 32'h1FC) wrap_seen = 1'b1;
            last_acc_adr = adr;
            exp_adr = (exp_adr + 32'd4) % (NPIX * 4);
            if (adr < NPIX * 4) mem[adr[8:2]] = dat;
            n_wr++;
            acks_since_fall++;
        end
        @(posedge clk);
        #1;
        if (hold) check("stall_hold", {stb, we, adr, dat}, {1'b1, held});
        if (!rst && prev_stb && !stb) begin
            n_falls++;
            check("burst_len", acks_since_fall, B);
            acks_since_fall = 0;
            pause_adr = adr;
            in_pause = 1'b1;
            low_cnt = 1;
        end else if (in_pause && !stb) begin
            low_cnt++;
        end else if (in_pause && stb) begin
            in_pause = 1'b0;
            check("pause_len", low_cnt, 1);
            check("pause_adr", adr, pause_adr);
        end
    endtask

    task automatic check_image(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] !== grid_px(i)) errs++;
        check(tag, errs, 0);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_book();
    endtask

    initial begin
        int          cycles;
        logic [31:0] adr_snap;
        rand_ack = 1'b0;
        ack = 1'b1;
        stall = 0;
        clear_book();
        rst = 1'b1;
        tick();
        tick();
        check("rst_bus", {cyc, stb, we, adr}, 35'd0);
        check("rst_status", {done, frame_count}, 9'd0);
        check("const_sigs", {sel, cti, bte}, {4'b1111, 3'b000, 2'b00});

        rst = 1'b0;
        clear_book();
        tick();
        cycles = 1;
        check("first_word", {cyc, stb, we, adr, dat}, {3'b111, 32'd0, 32'h00FFFFFF});

`ifdef MIRE_CONTINUOUS_EN
        while (frame_count != 8'd3 && cycles < 2000) begin
            tick();
            cycles++;
        end
        check("cont_frames", frame_count, 8'd3);
        check("cont_done", done, 1'b0);
        check("cont_writes", n_wr, 3 * NPIX);
        check("cont_wrap", wrap_seen, 1'b1);
        check_image("cont_image");
        check("cont_adr0", adr, 32'd0);
`else
        // Zero-wait slave, ack held high throughout, including pauses.
        while (!done && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("frame_cycles", cycles, 144);
        check("done_set", {done, cyc, stb}, 3'b100);
        check("frame_count1", frame_count, 8'd1);
        check("writes", n_wr, NPIX);
        check("falls", n_falls, NPIX / B);
        check("px_x5_y1", mem[37], 32'h0);
        check("px_x16_y3", mem[112], 32'h00FFFFFF);
        check("px_x0_y0", mem[0], 32'h00FFFFFF);
        check_image("image_fast");

        // Acks while DONE must change nothing.
        adr_snap = adr;
        for (int i = 0; i < 5; i++) tick();
        check("done_hold", {done, stb, cyc, adr, frame_count}, {3'b100, adr_snap, 8'd1});

        // Random 0-5 cycle stalls.
        reset_pulse();
        rand_ack = 1'b1;
        stall = 0;
        cycles = 0;
        while (!done && cycles < 5000) begin
            tick();
            cycles++;
        end
        rand_ack = 1'b0;
        ack = 1'b1;
        check("stall_done", done, 1'b1);
        check("stall_writes", n_wr, NPIX);
        check("stall_frames", frame_count, 8'd1);
        check_image("image_stall");

        // Reset at word 50 discards the pending ack and restarts at pixel 0.
        reset_pulse();
        cycles = 0;
        while (n_wr < 50 && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("reach_w50", n_wr, 50);
        rst = 1'b1;
        tick();
        check("mid_rst", {cyc, stb, adr, frame_count, done}, 43'd0);
        rst = 1'b0;
        clear_book();
        tick();
        check("restart", {cyc, stb, adr, dat}, {2'b11, 32'd0, 32'h00FFFFFF});
        cycles = 1;
        while (!done && cycles < 1000) begin
            tick();
            cycles++;
        end
        check("rst_frame_cycles", cycles, 144);
        check("rst_writes", n_wr, NPIX);
        check("rst_frames", frame_count, 8'd1);
        check_image("image_rst");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
